serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell, operand shift registers and a bit counter.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic d_bit;
    logic br_next;
    logic ready;

    // One full-subtractor cell on the current LSBs; the borrow ripples through br_q.
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        if (ready) begin
            if (start) begin
                a_d     = a;
                b_d     = b;
                br_d    = bin;
                r_d     = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            r_d   = {d_bit, r_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            // The last bit is folded straight into the published result on this edge.
            if (cnt_q == LAST_BIT) begin
                diff_d  = {d_bit, r_q[WIDTH-1:1]};
                bout_d  = br_next;
                state_d = ST_DONE;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            r_q     <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed handshake scenarios plus
// exhaustive WIDTH=4 and random WIDTH=8 sweeps against plain integer subtraction.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4, b4;
    logic       bin4;
    logic       busy4, done4;
    logic [3:0] diff4;
    logic       bout4;

    logic       start8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       busy8, done8;
    logic [7:0] diff8;
    logic       bout8;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to WIDTH bits, borrow = negative result.
    function automatic int refDiff(input int av, input int bv, input int binv, input int w);
        int e;
        e = av - bv - binv;
        return e & ((1 << w) - 1);
    endfunction

    function automatic int refBout(input int av, input int bv, input int binv);
        return (av - bv - binv < 0) ? 1 : 0;
    endfunction

    // Called at a negedge with the WIDTH=4 block idle; returns with it idle again.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic binv,
                                 input bit fullTiming);
        start4 = 1'b1; a4 = av; b4 = bv; bin4 = binv;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            if (fullTiming) begin
                checkOutput("busy4_run", int'(busy4), 1);
                checkOutput("done4_run", int'(done4), 0);
            end
            @(negedge clk);
        end
        if (fullTiming) begin
            checkOutput("done4_pulse", int'(done4), 1);
            checkOutput("busy4_done", int'(busy4), 0);
        end
        checkOutput("diff4", int'(diff4), refDiff(int'(av), int'(bv), int'(binv), 4));
        checkOutput("bout4", int'(bout4), refBout(int'(av), int'(bv), int'(binv)));
        @(negedge clk);
        if (fullTiming) begin
            checkOutput("done4_after", int'(done4), 0);
            checkOutput("diff4_hold", int'(diff4), refDiff(int'(av), int'(bv), int'(binv), 4));
        end
    endtask

    task automatic runOp8(input logic [7:0] av, input logic [7:0] bv, input logic binv);
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = binv;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        for (int i = 0; i < 8; i++) @(negedge clk);
        checkOutput("done8_pulse", int'(done8), 1);
        checkOutput("diff8", int'(diff8), refDiff(int'(av), int'(bv), int'(binv), 8));
        checkOutput("bout8", int'(bout8), refBout(int'(av), int'(bv), int'(binv)));
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] qa[6];
        logic [3:0] qb[6];
        logic       qbin[6];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #3;
        checkOutput("rst_busy4", int'(busy4), 0);
        checkOutput("rst_done4", int'(done4), 0);
        checkOutput("rst_diff4", int'(diff4), 0);
        checkOutput("rst_bout4", int'(bout4), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the worked examples.
        applyStimulus(4'd9, 4'd3, 1'b0, 1'b1);
        applyStimulus(4'd3, 4'd9, 1'b0, 1'b1);
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b1);
        applyStimulus(4'd15, 4'd15, 1'b0, 1'b1);

        // start during RUN is ignored and operand changes after capture have no effect.
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        checkOutput("ign_busy1", int'(busy4), 1);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'b1;
        checkOutput("ign_busy3", int'(busy4), 1);
        @(negedge clk);
        a4 = 4'($urandom); b4 = 4'($urandom);
        checkOutput("ign_busy4", int'(busy4), 1);
        checkOutput("ign_done_early", int'(done4), 0);
        @(negedge clk);
        checkOutput("ign_done", int'(done4), 1);
        checkOutput("ign_diff", int'(diff4), 6);
        checkOutput("ign_bout", int'(bout4), 0);
        @(negedge clk);
        checkOutput("ign_idle", int'(busy4) + int'(done4), 0);

        // Back-to-back operations with start held high.
        for (int k = 0; k < 6; k++) begin
            qa[k] = 4'($urandom); qb[k] = 4'($urandom); qbin[k] = 1'($urandom);
        end
        start4 = 1'b1; a4 = qa[0]; b4 = qb[0]; bin4 = qbin[0];
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("b2b_busy", int'(busy4), 1);
                if (i == 0) begin
                    a4 = 4'($urandom); b4 = 4'($urandom);
                end
                @(negedge clk);
            end
            checkOutput("b2b_done", int'(done4), 1);
            checkOutput("b2b_diff", int'(diff4),
                        refDiff(int'(qa[k]), int'(qb[k]), int'(qbin[k]), 4));
            checkOutput("b2b_bout", int'(bout4), refBout(int'(qa[k]), int'(qb[k]), int'(qbin[k])));
            if (k < 5) begin
                a4 = qa[k+1]; b4 = qb[k+1]; bin4 = qbin[k+1];
            end else begin
                start4 = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("b2b_end_idle", int'(busy4) + int'(done4), 0);

        // Asynchronous reset mid-RUN aborts the operation.
        applyStimulus(4'd9, 4'd3, 1'b0, 1'b0);
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd1; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", int'(busy4), 0);
        checkOutput("arst_done", int'(done4), 0);
        checkOutput("arst_diff", int'(diff4), 0);
        checkOutput("arst_bout", int'(bout4), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("arst_no_done", int'(done4), 0);
            @(negedge clk);
        end
        applyStimulus(4'd7, 4'd2, 1'b1, 1'b1);

        // Exhaustive WIDTH=4 sweep.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    applyStimulus(4'(av), 4'(bv), 1'(ci), 1'b0);
                end
            end
        end

        // Random WIDTH=8 sweep, with the extremes included.
        runOp8(8'd0, 8'd255, 1'b1);
        runOp8(8'd255, 8'd0, 1'b0);
        runOp8(8'd128, 8'd128, 1'b1);
        for (int k = 0; k < 200; k++) begin
            runOp8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
